// File: rtl/chain_timer_ctrl_if.sv
// Request/status bundle between the chain timer controller and the user module / counter datapath.
// start/pause/clear are levels sampled every clock (no handshake); all outputs are registered one-cycle pulses except busy/done.
interface chain_timer_ctrl_if #(
    parameter int STAGES = 4
);
    logic              start;
    logic              pause;
    logic              clear;
    logic [STAGES-1:0] carry;
    logic [STAGES-1:0] stage_en;
    logic              stage_clr;
    logic              tick;
    logic              busy;
    logic              done;

    modport master (
        input  start, pause, clear, carry,
        output stage_en, stage_clr, tick, busy, done
    );

    modport slave (
        output start, pause, clear, carry,
        input  stage_en, stage_clr, tick, busy, done
    );
endinterface

// File: rtl/chain_timer_ctrl.sv
// Run/pause/clear sequencer and prescaler for a cascaded counter chain.
// Define CHAIN_TIMER_AUTORELOAD_EN to free-run the chain at terminal count instead of stopping in DONE.
module chain_timer_ctrl #(
    parameter int DIV    = 1000,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    chain_timer_ctrl_if.master  bus,
    output logic [1:0]          state_dbg
);
    localparam int            PW   = $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [PW-1:0]     pcnt;
    logic [STAGES-1:0] en_mask;
    logic              ripple;

    assign state_dbg = state;

    // Stage i counts when every lower stage sits at terminal count.
    always_comb begin
        en_mask = '0;
        ripple  = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            en_mask[i] = ripple;
            ripple     = ripple & bus.carry[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pcnt          <= '0;
            bus.stage_en  <= '0;
            bus.stage_clr <= 1'b0;
            bus.tick      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.stage_en  <= '0;
            bus.stage_clr <= 1'b0;
            bus.tick      <= 1'b0;
`ifdef CHAIN_TIMER_AUTORELOAD_EN
            bus.done      <= 1'b0;
`endif
            if (bus.clear) begin
                state         <= IDLE;
                pcnt          <= '0;
                bus.stage_clr <= 1'b1;
                bus.busy      <= 1'b0;
                bus.done      <= 1'b0;
            end else if (bus.start && state != RUN) begin
                // Resume from PAUSED keeps the partial prescaler period.
                if (state == DONE) begin
                    pcnt          <= '0;
                    bus.stage_clr <= 1'b1;
                    bus.done      <= 1'b0;
                end
                state    <= RUN;
                bus.busy <= 1'b1;
            end else if (bus.pause && state == RUN) begin
                state    <= PAUSED;
                bus.busy <= 1'b0;
            end else if (state == RUN) begin
                if (pcnt == PMAX) begin
                    pcnt         <= '0;
                    bus.tick     <= 1'b1;
                    bus.stage_en <= en_mask;
                    if (&bus.carry) begin
`ifdef CHAIN_TIMER_AUTORELOAD_EN
                        bus.done <= 1'b1;
`else
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
`endif
                    end
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end
        end
    end
endmodule
